synth_sample_buffer: RTL and testbench

Conditions raw signed synthesizer samples into unsigned 10-bit DAC codes and buffers them for the audio sampler stage. It sits directly upstream of the sampler: it accepts samples from the synth core over a valid/ready handshake. It applies volume attenuation and mute, converts to offset binary, and holds results in a small FIFO. The sampler drains the FIFO one code per `synth_ready` pulse, which occurs every 2500 cycles.

---
 rtl/synth_sample_buffer_pkg.sv | 13 +
 rtl/synth_sample_buffer_fifo.sv | 61 ++++++
 rtl/synth_sample_buffer.sv | 90 +++++++++
 tb/tb_synth_sample_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_sample_buffer_pkg.sv
// Shared audio constants and helpers for the synth-to-sampler path.
package synth_sample_buffer_pkg;

   localparam int OUT_W_DEF     = 10;
   localparam int DAC_MID       = 512;
   localparam int SAMPLE_PERIOD = 2500;

   // Two's complement to offset binary: flip the sign bit of a width-bit code.
   function automatic logic [31:0] to_offset(input logic [31:0] code, input int width);
      return code ^ (32'd1 << (width - 1));
   endfunction

endpackage

// File: rtl/synth_sample_buffer_fifo.sv
// Small synchronous FIFO holding conditioned DAC codes; memory is not reset.
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int OUT_W = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [OUT_W-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [OUT_W-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   fill_level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o       = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o      = (cnt_q == '0);
   assign do_push      = push_i && !full_o;
   assign do_pop       = pop_i && !empty_o;
   assign head_o       = mem[rd_ptr_q];
   assign fill_level_o = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/synth_sample_buffer.sv
// Scales/mutes signed synth samples into offset-binary DAC codes and buffers
// them for the sampler, which pops one code per synth_ready pulse.
module synth_sample_buffer
   import synth_sample_buffer_pkg::*;
#(
   parameter int IN_W  = 14,
   parameter int OUT_W = OUT_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [IN_W-1:0]         in_sample,
   output logic                    in_ready,
   input  logic [2:0]              volume,
   input  logic                    mute,
   input  logic                    synth_ready,
   output logic                    synth_valid,
   output logic [OUT_W-1:0]        scaled_synth_code,
   output logic [$clog2(DEPTH):0]  fill_level,
   output logic [7:0]              underflow_count
);

   localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

   logic                   s1_valid_q, s1_valid_d;
   logic [OUT_W-1:0]       s1_code_q, s1_code_d;
   logic [7:0]             underflow_q, underflow_d;
   logic signed [IN_W-1:0] shifted;
   logic [OUT_W-1:0]       conv_code;
   logic [OUT_W-1:0]       fifo_head;
   logic                   fifo_full, fifo_empty;
   logic                   accept, push, pop;

   // Truncating to the top OUT_W bits cannot overflow, so no saturation.
   assign shifted   = $signed(in_sample) >>> volume;
   assign conv_code = OUT_W'(to_offset(32'(shifted[IN_W-1 -: OUT_W]), OUT_W));

   // Fullness is judged before any same-cycle pop.
   assign push        = s1_valid_q && !fifo_full;
   assign in_ready    = !s1_valid_q || push;
   assign accept      = in_valid && in_ready;
   assign synth_valid = !fifo_empty;
   assign pop         = synth_ready && synth_valid;

   assign scaled_synth_code = fifo_empty ? MID : fifo_head;
   assign underflow_count   = underflow_q;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_code_d   = s1_code_q;
      underflow_d = underflow_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_code_d  = mute ? MID : conv_code;
      end else if (push) begin
         s1_valid_d = 1'b0;
      end
      if (synth_ready && !synth_valid && (underflow_q != 8'hFF))
         underflow_d = underflow_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q  <= 1'b0;
         s1_code_q   <= MID;
         underflow_q <= 8'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_code_q   <= s1_code_d;
         underflow_q <= underflow_d;
      end
   end

   sample_fifo #(
      .DEPTH (DEPTH),
      .OUT_W (OUT_W)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .push_data_i  (s1_code_q),
      .pop_i        (pop),
      .head_o       (fifo_head),
      .fill_level_o (fill_level),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

endmodule

// File: tb/tb_synth_sample_buffer.sv
// Scoreboard bench for synth_sample_buffer: expected codes queued on accept,
// compared on pop.
module tb_synth_sample_buffer;
   import synth_sample_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [13:0] in_sample = '0;
   logic        in_ready;
   logic [2:0]  volume = '0;
   logic        mute = 1'b0;
   logic        synth_ready = 1'b0;
   logic        synth_valid;
   logic [9:0]  scaled_synth_code;
   logic [2:0]  fill_level;
   logic [7:0]  underflow_count;

   int n_checks = 0;
   int n_errors = 0;
   int sb_q[$];
   int sb_exp;

   always #5 clk = ~clk;

   synth_sample_buffer dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_sample         (in_sample),
      .in_ready          (in_ready),
      .volume            (volume),
      .mute              (mute),
      .synth_ready       (synth_ready),
      .synth_valid       (synth_valid),
      .scaled_synth_code (scaled_synth_code),
      .fill_level        (fill_level),
      .underflow_count   (underflow_count)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Integer reference: floor-divide by 2^volume, keep top 10 of 14 bits, re-bias.
   function automatic int model_code(input logic [13:0] s, input logic [2:0] v, input logic m);
      int x;
      if (m) return DAC_MID;
      x = int'($signed(s));
      x = x >>> v;
      x = x >>> 4;
      return x + DAC_MID;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
      end else begin
         if (synth_ready && synth_valid) begin
            if (sb_q.size() == 0) begin
               check_val("sb_unexpected_pop", 32'(scaled_synth_code), 32'hFFFF_FFFF);
            end else begin
               sb_exp = sb_q.pop_front();
               check_val("sb_code", 32'(scaled_synth_code), 32'(sb_exp));
            end
         end
         if (!synth_valid) check_val("idle_mid", 32'(scaled_synth_code), 32'(DAC_MID));
         if (in_valid && in_ready) sb_q.push_back(model_code(in_sample, volume, mute));
      end
   end

   task automatic send(input logic [13:0] s, input logic [2:0] v, input logic m);
      logic done;
      done = 1'b0;
      in_sample = s;
      volume    = v;
      mute      = m;
      in_valid  = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_val("send_accept", 32'(done), 32'd1);
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         synth_ready = synth_valid;
      end
      @(posedge clk);
      #1;
      synth_ready = 1'b0;
      check_val("drain_sb_empty", 32'(sb_q.size()), 32'd0);
      check_val("drain_valid", 32'(synth_valid), 32'd0);
   endtask

   task automatic pulse_ready();
      @(posedge clk);
      #1;
      synth_ready = 1'b1;
      @(posedge clk);
      #1;
      synth_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  acc;
      int  idx;
      logic take;
      logic saw_zero;
      logic [7:0] uf_before;

      // Held in reset with random inputs
      repeat (5) begin
         @(posedge clk);
         #1;
         in_valid    = 1'($urandom);
         in_sample   = 14'($urandom);
         volume      = 3'($urandom);
         mute        = 1'($urandom);
         synth_ready = 1'($urandom);
         #1;
         check_val("rst_valid", 32'(synth_valid), 32'd0);
         check_val("rst_code", 32'(scaled_synth_code), 32'd512);
         check_val("rst_in_ready", 32'(in_ready), 32'd1);
         check_val("rst_underflow", 32'(underflow_count), 32'd0);
         check_val("rst_fill", 32'(fill_level), 32'd0);
      end
      in_valid = 1'b0; synth_ready = 1'b0; mute = 1'b0; volume = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Latency and the negative full-scale code
      send(14'h2000, 3'd0, 1'b0);
      check_val("lat_not_yet", 32'(synth_valid), 32'd0);
      @(posedge clk);
      #1;
      check_val("lat_valid", 32'(synth_valid), 32'd1);
      check_val("conv_neg_fs", 32'(scaled_synth_code), 32'd0);
      drain(4);

      // Conversion table
      send(14'h1FFF, 3'd0, 1'b0);
      send(14'h2000, 3'd0, 1'b0);
      send(14'h0000, 3'd0, 1'b0);
      send(14'h1FFF, 3'd2, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      check_val("conv_fill4", 32'(fill_level), 32'd4);
      check_val("conv_pos_fs", 32'(scaled_synth_code), 32'd1023);
      drain(8);

      // Mute applies at capture; later changes must not affect the stored code
      send(14'h1FFF, 3'd0, 1'b1);
      mute = 1'b0; volume = 3'd7;
      @(posedge clk);
      #1;
      check_val("mute_code", 32'(scaled_synth_code), 32'd512);
      check_val("mute_valid", 32'(synth_valid), 32'd1);
      drain(4);
      volume = 3'd0;

      // Fill and backpressure
      idx = 1; acc = 0;
      in_sample = 14'(idx); in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         take = in_ready;
         @(posedge clk);
         #1;
         if (take) begin acc++; idx++; in_sample = 14'(idx); end
      end
      check_val("bp_accepted", 32'(acc), 32'd5);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      check_val("bp_fill", 32'(fill_level), 32'd4);
      synth_ready = 1'b1;
      @(posedge clk);
      #1;
      synth_ready = 1'b0;
      check_val("bp_ready_after_pop", 32'(in_ready), 32'd1);
      check_val("bp_fill_after_pop", 32'(fill_level), 32'd3);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_val("bp_refill", 32'(fill_level), 32'd4);
      drain(12);

      // Simultaneous push/pop at fill 2 across pointer wrap
      send(14'($urandom), 3'd0, 1'b0);
      send(14'($urandom), 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check_val("pp_fill_start", 32'(fill_level), 32'd2);
      in_sample = 14'($urandom); in_valid = 1'b1;
      @(posedge clk);
      #1;
      synth_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_sample = 14'($urandom);
         @(negedge clk);
         check_val("pp_fill", 32'(fill_level), 32'd2);
         check_val("pp_in_ready", 32'(in_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; synth_ready = 1'b0;
      check_val("pp_fill_end", 32'(fill_level), 32'd2);
      drain(8);

      // Underflow saturation
      check_val("uf_start", 32'(underflow_count), 32'd0);
      repeat (100) pulse_ready();
      check_val("uf_100", 32'(underflow_count), 32'd100);
      repeat (200) pulse_ready();
      check_val("uf_sat", 32'(underflow_count), 32'd255);

      // Async reset mid-cycle with data buffered
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check_val("uf_cleared", 32'(underflow_count), 32'd0);
      send(14'h0100, 3'd0, 1'b0);
      send(14'h0200, 3'd0, 1'b0);
      send(14'h0300, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check_val("mid_fill3", 32'(fill_level), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check_val("mid_valid", 32'(synth_valid), 32'd0);
      check_val("mid_code", 32'(scaled_synth_code), 32'd512);
      check_val("mid_in_ready", 32'(in_ready), 32'd1);
      check_val("mid_fill", 32'(fill_level), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("post_rst_idle", 32'(synth_valid), 32'd0);

      // Sampler cadence with a continuous source
      uf_before = underflow_count;
      saw_zero  = 1'b0;
      in_sample = 14'($urandom); volume = 3'($urandom); mute = 1'($urandom_range(0, 7) == 0);
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 6 * SAMPLE_PERIOD; cyc++) begin
         @(negedge clk);
         take = in_ready;
         if (cyc > 3 && fill_level == 3'd0) saw_zero = 1'b1;
         @(posedge clk);
         #1;
         if (take) begin
            in_sample = 14'($urandom);
            volume    = 3'($urandom);
            mute      = ($urandom_range(0, 7) == 0);
         end
         synth_ready = ((cyc % SAMPLE_PERIOD) == SAMPLE_PERIOD - 1);
      end
      in_valid = 1'b0; synth_ready = 1'b0; mute = 1'b0;
      check_val("cad_never_empty", 32'(saw_zero), 32'd0);
      check_val("cad_no_underflow", 32'(underflow_count), 32'(uf_before));
      drain(12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
